// File: rtl/cond_exec_unit_pkg.sv
// Shared NZCV bit positions and condition-code encodings.
// Also imported by the ALU, the decoder and the branch unit.
package cond_exec_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_exec_unit_cond_eval.sv
// Combinational condition check: Cond x NZCV -> pass.
// Kept free of state so the branch unit can reuse it.
module cond_eval
  import cond_exec_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution stage between ALU and writeback: owns NZCV, commits or
// squashes each result, and counts squashes. One-deep valid/ready register.
module cond_exec_unit
  import cond_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Result_In,
  input  logic [3:0]        Flags_In,
  input  logic [3:0]        Cond,
  input  logic              S,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Result,
  output logic              Out_WrEn,
  output logic [3:0]        Flags_Out,
  output logic [CNT_W-1:0]  Squash_Count
);

  logic accept;
  logic pass;

  // Cond always sees the committed flags; a preceding S=1 instruction has
  // already written them on its own accept edge, so no forwarding is needed.
  cond_eval u_cond_eval (
    .cond  (Cond),
    .flags (Flags_Out),
    .pass  (pass)
  );

  assign In_Ready = !Flush && (!Out_Valid || Out_Ready);
  assign accept   = In_Valid && In_Ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out_Valid    <= 1'b0;
      Out_Result   <= '0;
      Out_WrEn     <= 1'b0;
      Flags_Out    <= '0;
      Squash_Count <= '0;
    end else if (Flush) begin
      Out_Valid <= 1'b0;
    end else if (accept) begin
      Out_Valid  <= 1'b1;
      Out_Result <= Result_In;
      Out_WrEn   <= pass;
      if (pass && S) begin
        Flags_Out <= Flags_In;
      end
      if (!pass && (Squash_Count != {CNT_W{1'b1}})) begin
        Squash_Count <= Squash_Count + 1'b1;
      end
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Randomized and directed bench for cond_exec_unit against a queue-based
// reference of the stage and a table-driven condition evaluator.
module tb_cond_exec_unit;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_VS = 4'h6, C_HI = 4'h8,
                         C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB, C_AL = 4'hE,
                         C_NV = 4'hF;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result_in;
  logic [3:0]        flags_in;
  logic [3:0]        cond;
  logic              s;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_wren;
  logic [3:0]        flags_out;
  logic [CNT_W-1:0]  squash_count;

  cond_exec_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .In_Valid     (in_valid),
    .In_Ready     (in_ready),
    .Result_In    (result_in),
    .Flags_In     (flags_in),
    .Cond         (cond),
    .S            (s),
    .Flush        (flush),
    .Out_Valid    (out_valid),
    .Out_Ready    (out_ready),
    .Out_Result   (out_result),
    .Out_WrEn     (out_wren),
    .Flags_Out    (flags_out),
    .Squash_Count (squash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic              wren;
  } item_t;

  item_t             q[$];
  logic [3:0]        m_flags;
  int                m_count;
  logic [DATA_W-1:0] last_res;
  logic              last_wren;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c & !z;
      4'h9: return !c | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check handshake before the edge, advance the model, check after.
  task automatic step(input bit chk);
    bit    rdy, acc, ok;
    item_t it;
    #1;
    rdy = !flush && (q.size() == 0 || out_ready);
    if (chk && !rst) begin
      check_eq("in_ready", in_ready, rdy);
      if (q.size() != 0 && out_ready && !flush) begin
        check_eq("retire_result", out_result, q[0].result);
        check_eq("retire_wren", out_wren, q[0].wren);
      end
    end
    acc = in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_flags = 4'h0; m_count = 0; last_res = '0; last_wren = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        ok = cond_ok(cond, m_flags);
        it.result = result_in;
        it.wren   = ok;
        q.push_back(it);
        last_res  = result_in;
        last_wren = ok;
        if (ok && s) m_flags = flags_in;
        if (!ok && m_count < CNT_MAX) m_count++;
      end
    end
    #1;
    if (chk) begin
      check_eq("out_valid", out_valid, q.size() != 0);
      check_eq("out_result", out_result, last_res);
      check_eq("out_wren", out_wren, last_wren);
      check_eq("flags_out", flags_out, m_flags);
      check_eq("squash_count", squash_count, m_count);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cc, input logic ss,
                       input logic [3:0] f, input logic [DATA_W-1:0] r,
                       input logic fl, input logic ordy);
    in_valid = v; cond = cc; s = ss; flags_in = f; result_in = r;
    flush = fl; out_ready = ordy;
  endtask

  task automatic send(input logic [3:0] cc, input logic ss, input logic [3:0] f,
                      input logic [DATA_W-1:0] r);
    drive(1'b1, cc, ss, f, r, 1'b0, 1'b1);
    step(1'b1);
  endtask

  task automatic do_reset();
    drive(1'b0, C_AL, 1'b0, 4'h0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_flags = 4'h0; m_count = 0; last_res = '0; last_wren = 1'b0;
    do_reset();
    check_eq("rst_flags", flags_out, 4'h0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_count", squash_count, 16'h0);
    check_eq("rst_ready", in_ready, 1'b1);

    send(C_AL, 1'b1, 4'b1000, 32'd1);
    check_eq("t2_flags", flags_out, 4'b1000);
    send(C_LT, 1'b0, 4'h0, 32'd2);
    check_eq("t2_lt_wren", out_wren, 1'b1);
    send(C_GE, 1'b0, 4'h0, 32'd3);
    check_eq("t2_ge_wren", out_wren, 1'b0);
    check_eq("t2_count", squash_count, 16'd1);

    send(C_AL, 1'b1, 4'b0110, 32'd4);
    send(C_EQ, 1'b0, 4'h0, 32'd5);
    check_eq("t3_eq_wren", out_wren, 1'b1);
    send(C_NE, 1'b0, 4'h0, 32'd6);
    check_eq("t3_ne_wren", out_wren, 1'b0);
    send(C_AL, 1'b1, 4'b0010, 32'd7);
    send(C_HI, 1'b0, 4'h0, 32'd8);
    check_eq("t3_hi_wren", out_wren, 1'b1);
    send(C_LS, 1'b0, 4'h0, 32'd9);
    check_eq("t3_ls_wren", out_wren, 1'b0);

    send(C_AL, 1'b1, 4'b1001, 32'd10);
    send(C_GE, 1'b0, 4'h0, 32'd11);
    check_eq("t4_ge_wren", out_wren, 1'b1);
    send(C_LT, 1'b0, 4'h0, 32'd12);
    check_eq("t4_lt_wren", out_wren, 1'b0);
    send(C_VS, 1'b0, 4'h0, 32'd13);
    check_eq("t4_vs_wren", out_wren, 1'b1);
    send(C_LT, 1'b1, 4'b0100, 32'd14);
    check_eq("t4_squash_flags", flags_out, 4'b1001);

    send(C_AL, 1'b0, 4'h0, 32'hA5A5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, C_NV, 1'b0, 4'h0, 32'd100 + i, 1'b0, 1'b0);
      step(1'b1);
      check_eq("t5_hold_result", out_result, 32'hA5A5);
      check_eq("t5_hold_ready", in_ready, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      send((i % 2 == 0) ? C_NV : C_AL, 1'b0, 4'h0, 32'h200 + i);
      check_eq("t5_stream_result", out_result, 32'h200 + i);
      if (i % 2 == 0) check_eq("t5_nv_wren", out_wren, 1'b0);
    end

    drive(1'b1, C_AL, 1'b1, 4'b0101, 32'h300, 1'b1, 1'b1);
    step(1'b1);
    check_eq("t6_flush_valid", out_valid, 1'b0);
    check_eq("t6_flush_flags", flags_out, 4'b1001);
    check_eq("t6_flush_result", out_result, 32'h207);

    send(C_AL, 1'b0, 4'h0, 32'h400);
    drive(1'b1, C_AL, 1'b1, 4'b1111, 32'h401, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check_eq("rst_mid_flags", flags_out, 4'h0);
    check_eq("rst_mid_valid", out_valid, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), 4'($urandom),
            $urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step(1'b1);
    end
    rst = 1'b0;

    do_reset();
    for (int i = 0; i < CNT_MAX - 1; i++) begin
      drive(1'b1, C_NV, 1'b0, 4'h0, i, 1'b0, 1'b1);
      step(1'b0);
    end
    check_eq("sat_below", squash_count, 16'hFFFE);
    for (int i = 0; i < 10; i++) send(C_NV, 1'b0, 4'h0, 32'h500 + i);
    check_eq("sat_hold", squash_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
